// File: rtl/discrete_weighted_mixer.sv
// Time-multiplexed Q2.14 weighted sum of NUM_INPUTS signed channels.
// Define MIXER_SATURATE_EN to clamp the output; otherwise it wraps.
module discrete_weighted_mixer #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter logic [127:0] GAINS = {8{16'd4096}}
) (
  input  logic                     clk,
  input  logic                     I_RSTn,
  input  logic                     audio_clk_en,
  input  logic [16*NUM_INPUTS-1:0] in,
  output logic [15:0]              out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] cap_q [NUM_INPUTS];
  logic signed [15:0] cap_d [NUM_INPUTS];
  logic signed [35:0] acc_q, acc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [15:0]        out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic signed [15:0] samp;
  logic [15:0]        gain;
  logic signed [32:0] prod;
  logic [15:0]        res;

  // Shared multiplier: select the current channel and its gain
  always_comb begin
    samp = '0;
    gain = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (idx_q == IW'(i)) begin
        samp = cap_q[i];
        gain = GAINS[16*i +: 16];
      end
    end
    prod = samp * $signed({1'b0, gain});
  end

`ifdef MIXER_SATURATE_EN
  logic signed [35:0] r;

  // Floor-scale the sum and clamp it to the 16-bit range
  always_comb begin
    r = acc_q >>> 14;
    if (r > 36'sd32767) begin
      res = 16'h7fff;
    end else if (r < -36'sd32768) begin
      res = 16'h8000;
    end else begin
      res = r[15:0];
    end
  end
`else
  assign res = acc_q[29:14];
`endif

  // Next-state: capture, accumulate one channel per cycle, emit
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          for (int i = 0; i < NUM_INPUTS; i++) begin
            cap_d[i] = $signed(in[16*i +: 16]);
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + {{3{prod[32]}}, prod};
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        out_d       = res;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (audio_clk_en && state_q != IDLE) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q     <= IDLE;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cap_q[i] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
